apb_master: RTL and testbench

APB requester stage sitting directly upstream of the APB write slave FSM.
- Accepts single transfer requests from the local controller over a valid/ready handshake.
- Drives the APB SETUP and ACCESS phases (`psel`, `penable`, `pwrite`, `addr`, `pwdata`) and waits for `pready`.
- Returns a one-cycle response pulse carrying read data and an error flag.

---
 rtl/apb_master.sv | 140 ++++++++++++++
 tb/tb_apb_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: accepts single transfers over valid/ready, runs SETUP/ACCESS, returns a one-cycle response.
// Optional ACCESS timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_accept;
  logic              w_timeout;

  // req_ready is a pure function of state and rst so pready never reaches it combinationally.
  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;

  // Abort on the edge where the counter would reach the limit; pready on the same edge wins.
  assign w_timeout = (r_state == S_ACCESS) && !pready && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_SETUP) begin
        r_cnt <= '0;
      end else if (r_state == S_ACCESS && !pready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_ACCESS && pready) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // NOTE: all state updates use <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_psel      <= 2'b00;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_addr      <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_SETUP;
            r_pwrite <= req_write;
            r_addr   <= req_addr;
            r_pwdata <= req_wdata;
            r_psel   <= req_addr[ADDR_W-1] ? 2'b10 : 2'b01;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
        end
        S_ACCESS: begin
          if (pready) begin
            r_state     <= S_IDLE;
            r_psel      <= 2'b00;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_psel      <= 2'b00;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 2'b00;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  // addr/pwrite/pwdata deliberately survive the return to IDLE until the next accept.
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign addr      = r_addr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: reset, write, waited read, back-to-back, reset mid-ACCESS,
// pready outside ACCESS, and the ACCESS timeout (or indefinite wait when it is not built).
module tb_apb_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [1:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pwdata;
  logic              pready = 1'b0;
  logic [DATA_W-1:0] prdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int checks = 0;
  int errors = 0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .addr(addr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past one rising edge; outputs are observed and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL rst_psel got %b exp 00", psel); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", penable); end
    checks++; if (pwrite !== 1'b0 || addr !== '0 || pwdata !== '0) begin errors++; $display("FAIL rst_hold got pwrite=%b addr=%h pwdata=%h exp 0/0/0", pwrite, addr, pwdata); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp got v=%b d=%h e=%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF;
    tick();  // accept edge N
    req_valid = 1'b0;
    checks++; if (psel !== 2'b01 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup got psel=%b penable=%b exp 01/0", psel, penable); end
    checks++; if (pwdata !== 32'hDEAD_BEEF || addr !== 32'h0000_0010 || pwrite !== 1'b1) begin errors++; $display("FAIL wr_bus got addr=%h pwdata=%h pwrite=%b exp 00000010/deadbeef/1", addr, pwdata, pwrite); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy got %b exp 0", req_ready); end
    pready = 1'b1;
    tick();  // edge N+1: ACCESS
    checks++; if (psel !== 2'b01 || penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_access got psel=%b penable=%b rsp_valid=%b exp 01/1/0", psel, penable, rsp_valid); end
    tick();  // edge N+2: response
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin errors++; $display("FAIL wr_rsp got v=%b e=%b d=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (psel !== 2'b00 || penable !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle got psel=%b penable=%b ready=%b exp 00/0/1", psel, penable, req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse_width got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0004; req_wdata = 32'h0BAD_0BAD;
    prdata = 32'hFFFF_0000;
    tick();
    req_valid = 1'b0;
    checks++; if (psel !== 2'b10 || penable !== 1'b0 || pwrite !== 1'b0) begin errors++; $display("FAIL rd_setup got psel=%b penable=%b pwrite=%b exp 10/0/0", psel, penable, pwrite); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (penable !== 1'b1 || psel !== 2'b10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_access%0d got penable=%b psel=%b rsp_valid=%b exp 1/10/0", k, penable, psel, rsp_valid); end
      if (k == 4) begin pready = 1'b1; prdata = 32'h1234_5678; end
    end
    tick();
    pready = 1'b0; prdata = 32'hCAFE_F00D;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp got v=%b d=%h e=%b exp 1/12345678/0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if (penable !== 1'b0 || psel !== 2'b00) begin errors++; $display("FAIL rd_idle got penable=%b psel=%b exp 0/00", penable, psel); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hold got v=%b d=%h exp 0/12345678", rsp_valid, rsp_rdata); end
    checks++; if (addr !== 32'h8000_0004 || pwdata !== 32'h0BAD_0BAD) begin errors++; $display("FAIL rd_addr_hold got addr=%h pwdata=%h exp 80000004/0bad0bad", addr, pwdata); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1; req_wdata = 32'h1; pready = 1'b1;
    tick();  // first accept
    req_addr = 32'h2; req_wdata = 32'h2;
    pulses += int'(rsp_valid);
    checks++; if (psel !== 2'b01 || penable !== 1'b0 || addr !== 32'h1) begin errors++; $display("FAIL b2b_setup1 got psel=%b penable=%b addr=%h exp 01/0/1", psel, penable, addr); end
    tick();
    pulses += int'(rsp_valid);
    checks++; if (penable !== 1'b1 || addr !== 32'h1) begin errors++; $display("FAIL b2b_access1 got penable=%b addr=%h exp 1/1", penable, addr); end
    tick();
    pulses += int'(rsp_valid);
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || addr !== 32'h1) begin errors++; $display("FAIL b2b_rsp1 got v=%b ready=%b addr=%h exp 1/1/1", rsp_valid, req_ready, addr); end
    tick();  // second accept in the cycle the first response was visible
    req_valid = 1'b0;
    pulses += int'(rsp_valid);
    checks++; if (psel !== 2'b01 || penable !== 1'b0 || addr !== 32'h2 || pwdata !== 32'h2) begin errors++; $display("FAIL b2b_setup2 got psel=%b penable=%b addr=%h pwdata=%h exp 01/0/2/2", psel, penable, addr, pwdata); end
    tick();
    pulses += int'(rsp_valid);
    checks++; if (penable !== 1'b1 || addr !== 32'h2) begin errors++; $display("FAIL b2b_access2 got penable=%b addr=%h exp 1/2", penable, addr); end
    tick();
    pulses += int'(rsp_valid);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp2 got %b exp 1", rsp_valid); end
    pready = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); pulses += int'(rsp_valid); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0;
    tick();
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rmid_access got penable=%b exp 1", penable); end
    rst = 1'b1;
    tick();
    checks++; if (psel !== 2'b00 || penable !== 1'b0 || pwrite !== 1'b0 || addr !== '0 || pwdata !== '0) begin errors++; $display("FAIL rmid_bus got psel=%b pen=%b pw=%b addr=%h wd=%h exp all 0", psel, penable, pwrite, addr, pwdata); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rmid_rsp got v=%b d=%h e=%b ready=%b exp all 0", rsp_valid, rsp_rdata, rsp_err, req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); pulses += int'(rsp_valid); end
    pready = 1'b0;
    checks++; if (pulses !== 0 || penable !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got pulses=%0d penable=%b exp 0/0", pulses, penable); end
  endtask

  task automatic test_pready_outside();
    int pulses = 0;
    pready = 1'b1; prdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 2; i++) begin tick(); pulses += int'(rsp_valid); end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
    tick();
    req_valid = 1'b0;
    pulses += int'(rsp_valid);
    checks++; if (psel !== 2'b01 || penable !== 1'b0) begin errors++; $display("FAIL pout_setup got psel=%b penable=%b exp 01/0", psel, penable); end
    tick();
    pulses += int'(rsp_valid);
    checks++; if (penable !== 1'b1 || psel !== 2'b01) begin errors++; $display("FAIL pout_access got penable=%b psel=%b exp 1/01", penable, psel); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL pout_spurious got %0d exp 0", pulses); end
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL pout_rsp got v=%b d=%h exp 1/a5a5a5a5", rsp_valid, rsp_rdata); end
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; pready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_access%0d got penable=%b rsp_valid=%b exp 1/0", k, penable, rsp_valid); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin errors++; $display("FAIL to_abort got v=%b e=%b d=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (penable !== 1'b0 || psel !== 2'b00) begin errors++; $display("FAIL to_idle got penable=%b psel=%b exp 0/00", penable, psel); end
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin pready = 1'b1; prdata = 32'h0F0F_0F0F; end
    end
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0F0F_0F0F) begin errors++; $display("FAIL to_pready_wins got v=%b e=%b d=%h exp 1/0/0f0f0f0f", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int pulses = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040; pready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); pulses += int'(rsp_valid); end
    checks++; if (penable !== 1'b1 || pulses !== 0) begin errors++; $display("FAIL nto_wait got penable=%b pulses=%0d exp 1/0", penable, pulses); end
    pready = 1'b1; prdata = 32'h0F0F_0F0F;
    tick();
    pready = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0F0F_0F0F) begin errors++; $display("FAIL nto_rsp got v=%b e=%b d=%h exp 1/0/0f0f0f0f", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_reset_mid_access();
    test_pready_outside();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
